// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: RV32M funct3
// codes and the control FSM state encoding.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      MulDivOp;
  logic [XLEN-1:0] Operand1;
  logic [XLEN-1:0] Operand2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] MulDivOut;

  modport master (
    output start, MulDivOp, Operand1, Operand2, flush,
    input  busy, done, MulDivOut
  );

  modport slave (
    input  start, MulDivOp, Operand1, Operand2, flush,
    output busy, done, MulDivOut
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned step datapath: magnitudes and operand
// signs on entry, two's-complement correction of the raw result on exit.
module muldiv_signfix
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              sign_a,
  output logic              sign_b,
  input  logic [2*XLEN-1:0] raw,
  input  logic              neg,
  output logic [2*XLEN-1:0] fixed
);

  logic a_signed;
  logic b_signed;

  // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 only for MULH/DIV/REM;
  // 0x80000000 negates to itself and is then read as an unsigned magnitude
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sign_a   = a_signed & a[XLEN-1];
    sign_b   = b_signed & b[XLEN-1];
    mag_a    = sign_a ? -a : a;
    mag_b    = sign_b ? -b : b;
    fixed    = neg ? -raw : raw;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle, XLEN steps per op.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_t            state, state_nxt;
  logic [XLEN-1:0]   acc, lo, mcand, out_r;
  logic [2:0]        op_r;
  logic              neg;
  logic [CNT_W-1:0]  cnt;

  logic              accept, div_zero, div_ovf, special;
  logic              busy_c, done_c;
  logic [XLEN-1:0]   mag_a, mag_b, result;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] raw, fixed;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .op     (bus.MulDivOp),
    .a      (bus.Operand1),
    .b      (bus.Operand2),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .raw    (raw),
    .neg    (neg),
    .fixed  (fixed)
  );

  // Request decode: flush beats start; divide-by-zero and signed overflow skip CALC
  always_comb begin
    accept   = (state == IDLE) && bus.start && !bus.flush;
    div_zero = (bus.Operand2 == '0);
    div_ovf  = !bus.MulDivOp[0] && (bus.Operand1 == {1'b1, {(XLEN-1){1'b0}}})
               && (bus.Operand2 == '1);
    special  = bus.MulDivOp[2] && (div_zero || div_ovf);
  end

  // Step arithmetic: acc holds the product high half or the partial remainder
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
  end

  // Result selection: divides feed the low half only, negation mod 2^XLEN is the same
  always_comb begin
    raw    = op_r[2] ? {{XLEN{1'b0}}, (op_r[1] ? acc : lo)} : {acc, lo};
    result = (op_r[2] || op_r[1:0] == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and handshake outputs; a flush in FIN suppresses done
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = special ? FIN : CALC;
      CALC: begin
        busy_c = 1'b1;
        if (cnt == '0) state_nxt = FIN;
      end
      FIN: begin
        done_c    = !bus.flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.MulDivOut = done_c ? result : out_r;

  // Datapath: operand capture on accept, one radix-2 step per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      lo    <= '0;
      mcand <= '0;
      op_r  <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_r <= bus.MulDivOp;
      cnt  <= CNT_W'(XLEN - 1);
      if (special) begin
        lo    <= div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        acc   <= div_zero ? bus.Operand1 : '0;
        mcand <= '0;
        neg   <= 1'b0;
      end else if (bus.MulDivOp[2]) begin
        acc   <= '0;
        lo    <= mag_a;
        mcand <= mag_b;
        neg   <= bus.MulDivOp[1] ? sign_a : (sign_a ^ sign_b);
      end else begin
        acc   <= '0;
        lo    <= mag_b;
        mcand <= mag_a;
        neg   <= sign_a ^ sign_b;
      end
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      if (op_r[2]) begin
        if (!div_diff[XLEN]) begin
          acc <= div_diff[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b1};
        end else begin
          acc <= div_shift[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {acc, lo} <= {mul_sum, lo[XLEN-1:1]};
      end
    end
  end

  // Output holding register, updated only by a completed operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_r <= '0;
    else if (done_c) out_r <= result;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, busy length, specials,
// flush, asynchronous reset and start held while busy.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  muldiv_unit_if #(.XLEN(32)) mif ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    mif.start = 1'b1; mif.MulDivOp = op; mif.Operand1 = a; mif.Operand2 = b;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.MulDivOp = ~op;
    mif.Operand1 = ~a; mif.Operand2 = b ^ 32'h5a5a_5a5a;
    lat = 1; busy_cnt = 0;
    while (!mif.done && lat < 40) begin
      if (mif.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " done"}, {31'b0, mif.done}, 32'd1);
    check({tag, " val"}, mif.MulDivOut, exp);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
    @(posedge clk); #1;
    check({tag, " hold"}, mif.MulDivOut, exp);
    check({tag, " done pulse"}, {31'b0, mif.done}, 32'd0);
  endtask

  initial begin
    int n_done;
    int lat;
    int done_lat;
    logic [31:0] done_val;

    rst = 1'b1;
    mif.start = 1'b0; mif.flush = 1'b0; mif.MulDivOp = OP_MUL;
    mif.Operand1 = '0; mif.Operand2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, mif.busy}, 32'd0);
    check("reset done", {31'b0, mif.done}, 32'd0);
    check("reset out", mif.MulDivOut, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("mul 7x6",      OP_MUL,    32'd7,          32'd6,          32'd42,         33);
    do_op("mulhu ffxff",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  33);
    do_op("mulh min2",    OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  33);
    do_op("mulhsu -1x2",  OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  33);
    do_op("mul -3x5",     OP_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  33);
    do_op("div -7/2",     OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
    do_op("rem -7/2",     OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
    do_op("divu 100/7",   OP_DIVU,   32'd100,        32'd7,          32'd14,         33);
    do_op("remu 100/7",   OP_REMU,   32'd100,        32'd7,          32'd2,          33);

    // flush at cycle 10 of a DIVU
    @(negedge clk);
    mif.start = 1'b1; mif.MulDivOp = OP_DIVU; mif.Operand1 = 32'd1000; mif.Operand2 = 32'd3;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); mif.flush = 1'b1;
    @(posedge clk); #1; mif.flush = 1'b0;
    check("flush busy", {31'b0, mif.busy}, 32'd0);
    check("flush done", {31'b0, mif.done}, 32'd0);
    check("flush out", mif.MulDivOut, 32'd2);
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mif.done) n_done++;
    end
    check("flush no done", n_done, 32'd0);
    check("flush out kept", mif.MulDivOut, 32'd2);
    do_op("mul 3x3", OP_MUL, 32'd3, 32'd3, 32'd9, 33);

    // flush and start in the same IDLE cycle
    @(negedge clk);
    mif.start = 1'b1; mif.flush = 1'b1; mif.MulDivOp = OP_MUL;
    mif.Operand1 = 32'd5; mif.Operand2 = 32'd5;
    @(posedge clk); #1;
    mif.start = 1'b0; mif.flush = 1'b0;
    check("flush+start busy", {31'b0, mif.busy}, 32'd0);
    check("flush+start done", {31'b0, mif.done}, 32'd0);
    check("flush+start out", mif.MulDivOut, 32'd9);

    do_op("div 5/0",      OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("rem 5/0",      OP_REM,  32'd5,         32'd0,         32'd5,         1);
    do_op("divu 5/0",     OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("div ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    mif.start = 1'b1; mif.MulDivOp = OP_MULHU;
    mif.Operand1 = 32'h1234_5678; mif.Operand2 = 32'h9abc_def0;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", {31'b0, mif.busy}, 32'd0);
    check("midrst done", {31'b0, mif.done}, 32'd0);
    check("midrst out", mif.MulDivOut, 32'd0);
    @(negedge clk); rst = 1'b0;

    // start held high through the whole operation
    @(negedge clk);
    mif.start = 1'b1; mif.MulDivOp = OP_MUL; mif.Operand1 = 32'd7; mif.Operand2 = 32'd6;
    n_done = 0; lat = 0; done_lat = 0; done_val = '0;
    repeat (80) begin
      @(posedge clk); #1;
      lat++;
      if (mif.done) begin
        n_done++;
        if (n_done == 1) begin
          done_lat = lat;
          done_val = mif.MulDivOut;
        end
        mif.start = 1'b0;
      end
    end
    mif.start = 1'b0;
    check("held start dones", n_done, 32'd1);
    check("held start latency", done_lat, 32'd33);
    check("held start val", done_val, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
